// File: rtl/io_xbar_input_port_pkg.sv
// Shared definitions for the IO crossbar input port: network widths, route encodings, FSM states.
// Network widths fall back to OpenPiton defaults when network_define.v has not been read first.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif

package io_xbar_input_port_pkg;

  localparam int DATA_W    = `DATA_WIDTH;
  localparam int PAYLOAD_W = `PAYLOAD_LEN;
  localparam int LEN_MSB   = `DATA_WIDTH - `CHIP_ID_WIDTH - 2*`XY_WIDTH - 4;

  localparam logic [1:0] IO_XBAR_ROUTE_0 = 2'd0;
  localparam logic [1:0] IO_XBAR_ROUTE_1 = 2'd1;
  localparam logic [1:0] IO_XBAR_ROUTE_2 = 2'd2;
  localparam logic [1:0] IO_XBAR_ROUTE_3 = 2'd3;

  typedef enum logic {
    IO_XBAR_IN_HEAD = 1'b0,
    IO_XBAR_IN_BODY = 1'b1
  } io_xbar_in_state_e;

  function automatic logic [3:0] route_onehot(input logic [1:0] route);
    logic [3:0] oh;
    oh = 4'b0000;
    case (route)
      IO_XBAR_ROUTE_0: oh = 4'b0001;
      IO_XBAR_ROUTE_1: oh = 4'b0010;
      IO_XBAR_ROUTE_2: oh = 4'b0100;
      IO_XBAR_ROUTE_3: oh = 4'b1000;
      default:         oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/io_xbar_input_fifo.sv
// Flit buffer for the crossbar input port; DEPTH must be a power of two so pointers wrap for free.
module io_xbar_input_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             empty_out,
  output logic             full_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_out = (count_q == '0);
  assign full_out  = (count_q == CW'(DEPTH));
  assign data_out  = mem_q[rd_ptr_q];
  assign pop_ok    = pop_in & ~empty_out;
  // A push into a full buffer only lands if the head leaves in the same cycle.
  assign push_ok   = push_in & (~full_out | pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/io_xbar_input_port.sv
// Crossbar input port: buffers flits, decodes headers, requests an output and returns yummy credits.
// Define IO_XBAR_INPUT_PROTOCOL_CHECK_EN to add the sticky err_out protocol checker.
module io_xbar_input_port
  import io_xbar_input_port_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ROUTE_LSB  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [`DATA_WIDTH-1:0] data_in,
  input  logic                   valid_in,
  output logic                   yummy_out,
  output logic [`DATA_WIDTH-1:0] data_out,
  output logic                   valid_out,
  output logic                   route_req_0_out,
  output logic                   route_req_1_out,
  output logic                   route_req_2_out,
  output logic                   route_req_3_out,
  output logic                   tail_out,
  input  logic                   thanks_0_in,
  input  logic                   thanks_1_in,
  input  logic                   thanks_2_in,
`ifdef IO_XBAR_INPUT_PROTOCOL_CHECK_EN
  input  logic                   thanks_3_in,
  output logic                   err_out
`else
  input  logic                   thanks_3_in
`endif
);

  io_xbar_in_state_e    state_q, state_d;
  logic [PAYLOAD_W-1:0] cnt_q, cnt_d;
  logic [1:0]           route_q, route_d;
  logic                 yummy_q, yummy_d;

  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 pop;
  logic [3:0]           thanks;
  logic [3:0]           req;
  logic [1:0]           hdr_route;
  logic [PAYLOAD_W-1:0] hdr_len;
  logic [1:0]           cur_route;

  io_xbar_input_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (`DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_in   (valid_in),
    .pop_in    (pop),
    .data_in   (data_in),
    .data_out  (data_out),
    .empty_out (fifo_empty),
    .full_out  (fifo_full)
  );

  assign valid_out = ~fifo_empty;
  assign thanks    = {thanks_3_in, thanks_2_in, thanks_1_in, thanks_0_in};
  assign hdr_route = data_out[ROUTE_LSB+1:ROUTE_LSB];
  assign hdr_len   = data_out[LEN_MSB -: PAYLOAD_W];
  // Body flits carry no route, so they follow the port latched from their header.
  assign cur_route = (state_q == IO_XBAR_IN_HEAD) ? hdr_route : route_q;
  assign pop       = valid_out & thanks[cur_route];
  assign req       = valid_out ? route_onehot(cur_route) : 4'b0000;

  assign route_req_0_out = req[0];
  assign route_req_1_out = req[1];
  assign route_req_2_out = req[2];
  assign route_req_3_out = req[3];
  assign yummy_out       = yummy_q;

  always_comb begin
    tail_out = 1'b0;
    if (valid_out) begin
      tail_out = (state_q == IO_XBAR_IN_HEAD) ? (hdr_len == '0) : (cnt_q == PAYLOAD_W'(1));
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    route_d = route_q;
    yummy_d = pop;
    if (pop) begin
      if (state_q == IO_XBAR_IN_HEAD) begin
        route_d = hdr_route;
        if (hdr_len != '0) begin
          cnt_d   = hdr_len;
          state_d = IO_XBAR_IN_BODY;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == PAYLOAD_W'(1)) begin
          state_d = IO_XBAR_IN_HEAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IO_XBAR_IN_HEAD;
      cnt_q   <= '0;
      route_q <= IO_XBAR_ROUTE_0;
      yummy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      route_q <= route_d;
      yummy_q <= yummy_d;
    end
  end

`ifdef IO_XBAR_INPUT_PROTOCOL_CHECK_EN
  logic err_q, err_d;
  logic ev_overflow;
  logic ev_wrong_thanks;
  logic ev_multi_thanks;

  assign ev_overflow     = valid_in & fifo_full & ~pop;
  assign ev_wrong_thanks = valid_out & |(thanks & ~route_onehot(cur_route));
  assign ev_multi_thanks = ($countones(thanks) > 1);
  assign err_out         = err_q;

  always_comb begin
    err_d = err_q | ev_overflow | ev_wrong_thanks | ev_multi_thanks;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (ev_overflow)     $display("io_xbar_input_port: overflow push dropped at %0t", $time);
      if (ev_wrong_thanks) $display("io_xbar_input_port: thanks on unselected port at %0t", $time);
      if (ev_multi_thanks) $display("io_xbar_input_port: multiple thanks bits at %0t", $time);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_io_xbar_input_port.sv
// Scoreboard bench for io_xbar_input_port; err_out is also checked when IO_XBAR_INPUT_PROTOCOL_CHECK_EN is defined.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef PAYLOAD_LEN
`define PAYLOAD_LEN 8
`endif
`ifndef CHIP_ID_WIDTH
`define CHIP_ID_WIDTH 14
`endif
`ifndef XY_WIDTH
`define XY_WIDTH 8
`endif

module tb_io_xbar_input_port;

  localparam int DW     = `DATA_WIDTH;
  localparam int LW     = `PAYLOAD_LEN;
  localparam int LMSB   = `DATA_WIDTH - `CHIP_ID_WIDTH - 2*`XY_WIDTH - 4;
  localparam int DEPTH  = 4;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_in;
  logic          valid_in;
  logic          yummy_out;
  logic [DW-1:0] data_out;
  logic          valid_out;
  logic [3:0]    req;
  logic          tail_out;
  logic [3:0]    thanks;
`ifdef IO_XBAR_INPUT_PROTOCOL_CHECK_EN
  logic          err_out;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: expected buffer contents plus the header/body tracking state.
  logic [DW-1:0] m_q[$];
  logic          m_body;
  logic [LW-1:0] m_cnt;
  logic [1:0]    m_route;
  logic          m_yummy;

  io_xbar_input_port #(.FIFO_DEPTH(DEPTH), .ROUTE_LSB(0)) dut (
    .clk             (clk),
    .reset           (reset),
    .data_in         (data_in),
    .valid_in        (valid_in),
    .yummy_out       (yummy_out),
    .data_out        (data_out),
    .valid_out       (valid_out),
    .route_req_0_out (req[0]),
    .route_req_1_out (req[1]),
    .route_req_2_out (req[2]),
    .route_req_3_out (req[3]),
    .tail_out        (tail_out),
    .thanks_0_in     (thanks[0]),
    .thanks_1_in     (thanks[1]),
    .thanks_2_in     (thanks[2]),
`ifdef IO_XBAR_INPUT_PROTOCOL_CHECK_EN
    .thanks_3_in     (thanks[3]),
    .err_out         (err_out)
`else
    .thanks_3_in     (thanks[3])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk_hdr(input logic [1:0] route, input logic [LW-1:0] len);
    logic [DW-1:0] h;
    h = DW'({$urandom(), $urandom()});
    h[1:0] = route;
    h[LMSB -: LW] = len;
    return h;
  endfunction

  function automatic logic [DW-1:0] mk_body();
    return DW'({$urandom(), $urandom()});
  endfunction

  function automatic logic [1:0] m_cur_route();
    logic [DW-1:0] h;
    if (m_q.size() == 0) return m_route;
    h = m_q[0];
    return m_body ? m_route : h[1:0];
  endfunction

  function automatic logic [3:0] exp_req();
    if (m_q.size() == 0) return 4'b0000;
    return 4'b0001 << m_cur_route();
  endfunction

  function automatic logic exp_tail();
    logic [DW-1:0] h;
    if (m_q.size() == 0) return 1'b0;
    h = m_q[0];
    return m_body ? (m_cnt == LW'(1)) : (h[LMSB -: LW] == '0);
  endfunction

  // Advance one clock, updating the model from the inputs that were presented before the edge.
  task automatic tick(output logic accepted);
    logic          pop;
    logic          push;
    logic [DW-1:0] h;
    logic [DW-1:0] din;
    logic [1:0]    cr;
    pop = 1'b0;
    h   = '0;
    cr  = m_cur_route();
    din = data_in;
    if (m_q.size() > 0) begin
      h   = m_q[0];
      pop = thanks[cr];
    end
    push = valid_in && ((m_q.size() < DEPTH) || pop);
    @(posedge clk);
    #1;
    accepted = push && !reset;
    if (reset) begin
      m_q.delete();
      m_body  = 1'b0;
      m_cnt   = '0;
      m_route = 2'd0;
      m_yummy = 1'b0;
    end else begin
      if (pop) begin
        if (!m_body) begin
          m_route = cr;
          if (h[LMSB -: LW] != '0) begin
            m_cnt  = h[LMSB -: LW];
            m_body = 1'b1;
          end
        end else begin
          if (m_cnt == LW'(1)) m_body = 1'b0;
          m_cnt = m_cnt - 1'b1;
        end
        void'(m_q.pop_front());
      end
      if (push) m_q.push_back(din);
      m_yummy = pop;
    end
  endtask

  task automatic test_reset();
    logic acc;
    reset = 1'b1; valid_in = 1'b0; thanks = 4'b0; data_in = '0;
    tick(acc);
    tick(acc);
    total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", valid_out); end
    total++; if (yummy_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_yummy got=%b want=0", yummy_out); end
    total++; if (req !== 4'b0000) begin bad++; $display("[TB] FAIL reset_req got=%b want=0000", req); end
    total++; if (tail_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_tail got=%b want=0", tail_out); end
`ifdef IO_XBAR_INPUT_PROTOCOL_CHECK_EN
    total++; if (err_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_err got=%b want=0", err_out); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_single_flit();
    logic acc;
    valid_in = 1'b1; data_in = mk_hdr(2'd2, '0);
    tick(acc);
    valid_in = 1'b0;
    total++; if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", valid_out); end
    total++; if (data_out !== m_q[0]) begin bad++; $display("[TB] FAIL single_data got=%h want=%h", data_out, m_q[0]); end
    total++; if (req !== 4'b0100) begin bad++; $display("[TB] FAIL single_req got=%b want=0100", req); end
    total++; if (tail_out !== 1'b1) begin bad++; $display("[TB] FAIL single_tail got=%b want=1", tail_out); end
    thanks = 4'b0100;
    tick(acc);
    thanks = 4'b0000;
    total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL single_popped got=%b want=0", valid_out); end
    total++; if (yummy_out !== 1'b1) begin bad++; $display("[TB] FAIL single_yummy got=%b want=1", yummy_out); end
    tick(acc);
    total++; if (yummy_out !== 1'b0) begin bad++; $display("[TB] FAIL single_yummy_once got=%b want=0", yummy_out); end
  endtask

  // Streams a whole message while granting port 1 continuously.
  task automatic test_four_flit();
    logic          acc;
    logic [DW-1:0] stim[$];
    int            idx = 0;
    int            yum = 0;
    int            tails = 0;
    stim.push_back(mk_hdr(2'd1, LW'(3)));
    for (int i = 0; i < 3; i++) stim.push_back(mk_body());
    thanks = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      valid_in = (idx < stim.size());
      if (valid_in) data_in = stim[idx];
      tick(acc);
      if (acc) idx++;
      valid_in = 1'b0;
      total++; if (req !== exp_req()) begin bad++; $display("[TB] FAIL four_req c=%0d got=%b want=%b", c, req, exp_req()); end
      total++; if (tail_out !== exp_tail()) begin bad++; $display("[TB] FAIL four_tail c=%0d got=%b want=%b", c, tail_out, exp_tail()); end
      total++; if (yummy_out !== m_yummy) begin bad++; $display("[TB] FAIL four_yummy c=%0d got=%b want=%b", c, yummy_out, m_yummy); end
      if (m_q.size() > 0) begin
        total++; if (data_out !== m_q[0]) begin bad++; $display("[TB] FAIL four_data c=%0d got=%h want=%h", c, data_out, m_q[0]); end
      end
      if (yummy_out) yum++;
      if (tail_out) tails++;
    end
    thanks = 4'b0000;
    total++; if (yum != 4) begin bad++; $display("[TB] FAIL four_yummy_count got=%0d want=4", yum); end
    total++; if (tails != 1) begin bad++; $display("[TB] FAIL four_tail_count got=%0d want=1", tails); end
  endtask

  task automatic test_wrong_thanks();
    logic acc;
    valid_in = 1'b1; data_in = mk_hdr(2'd3, '0);
    tick(acc);
    valid_in = 1'b0; thanks = 4'b0001;
    tick(acc);
    thanks = 4'b0000;
    total++; if (valid_out !== 1'b1) begin bad++; $display("[TB] FAIL wrong_thanks_valid got=%b want=1", valid_out); end
    total++; if (yummy_out !== 1'b0) begin bad++; $display("[TB] FAIL wrong_thanks_yummy got=%b want=0", yummy_out); end
    total++; if (req !== 4'b1000) begin bad++; $display("[TB] FAIL wrong_thanks_req got=%b want=1000", req); end
`ifdef IO_XBAR_INPUT_PROTOCOL_CHECK_EN
    total++; if (err_out !== 1'b1) begin bad++; $display("[TB] FAIL wrong_thanks_err got=%b want=1", err_out); end
`endif
    thanks = 4'b1000;
    tick(acc);
    thanks = 4'b0000;
    total++; if (yummy_out !== 1'b1) begin bad++; $display("[TB] FAIL wrong_thanks_drain got=%b want=1", yummy_out); end
  endtask

  task automatic test_full();
    logic acc;
    int   drained = 0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      valid_in = 1'b1; data_in = mk_hdr(2'd2, '0);
      tick(acc);
    end
    total++; if (m_q.size() != DEPTH) begin bad++; $display("[TB] FAIL full_model_size got=%0d want=%0d", m_q.size(), DEPTH); end
    data_in = mk_hdr(2'd2, '0); thanks = 4'b0100;
    tick(acc);
    total++; if (acc !== 1'b1) begin bad++; $display("[TB] FAIL full_push_pop_accept got=%b want=1", acc); end
    valid_in = 1'b0;
    for (int c = 0; c < 8; c++) begin
      total++; if (valid_out !== (m_q.size() > 0)) begin bad++; $display("[TB] FAIL full_drain_valid c=%0d got=%b want=%b", c, valid_out, m_q.size() > 0); end
      if (m_q.size() > 0) begin
        drained++;
        total++; if (data_out !== m_q[0]) begin bad++; $display("[TB] FAIL full_drain_data c=%0d got=%h want=%h", c, data_out, m_q[0]); end
      end
      tick(acc);
    end
    thanks = 4'b0000;
    total++; if (drained != DEPTH) begin bad++; $display("[TB] FAIL full_drain_count got=%0d want=%0d", drained, DEPTH); end
  endtask

  // Output side grants whatever is requested, as an arbiter would.
  task automatic test_back_to_back();
    logic          acc;
    logic [DW-1:0] stim[$];
    int            idx = 0;
    stim.push_back(mk_hdr(2'd0, LW'(1)));
    stim.push_back(mk_body());
    stim.push_back(mk_hdr(2'd3, '0));
    for (int c = 0; c < 8; c++) begin
      valid_in = (idx < stim.size());
      if (valid_in) data_in = stim[idx];
      thanks = exp_req();
      tick(acc);
      if (acc) idx++;
      valid_in = 1'b0;
      total++; if (req !== exp_req()) begin bad++; $display("[TB] FAIL b2b_req c=%0d got=%b want=%b", c, req, exp_req()); end
      total++; if ($countones(req) > 1) begin bad++; $display("[TB] FAIL b2b_onehot c=%0d got=%b want=at_most_one", c, req); end
      total++; if (tail_out !== exp_tail()) begin bad++; $display("[TB] FAIL b2b_tail c=%0d got=%b want=%b", c, tail_out, exp_tail()); end
    end
    thanks = 4'b0000;
  endtask

  task automatic test_max_len();
    logic          acc;
    logic [DW-1:0] stim[$];
    int            idx = 0;
    int            tails = 0;
    int            yum = 0;
    int            flits = (1 << LW);
    stim.push_back(mk_hdr(2'd1, {LW{1'b1}}));
    for (int i = 1; i < flits; i++) stim.push_back(mk_body());
    stim.push_back(mk_hdr(2'd2, '0));
    for (int c = 0; c < flits + 8; c++) begin
      valid_in = (idx < stim.size());
      if (valid_in) data_in = stim[idx];
      thanks = (idx >= flits && m_q.size() == 1 && !m_body) ? 4'b0000 : 4'b0010;
      tick(acc);
      if (acc) idx++;
      valid_in = 1'b0;
      total++; if (req !== exp_req()) begin bad++; $display("[TB] FAIL max_req c=%0d got=%b want=%b", c, req, exp_req()); end
      total++; if (tail_out !== exp_tail()) begin bad++; $display("[TB] FAIL max_tail c=%0d got=%b want=%b", c, tail_out, exp_tail()); end
      if (tail_out && m_body) tails++;
      if (yummy_out) yum++;
    end
    total++; if (tails != 1) begin bad++; $display("[TB] FAIL max_body_tail_count got=%0d want=1", tails); end
    total++; if (yum != flits) begin bad++; $display("[TB] FAIL max_yummy_count got=%0d want=%0d", yum, flits); end
    total++; if (req !== 4'b0100) begin bad++; $display("[TB] FAIL max_next_hdr_req got=%b want=0100", req); end
    thanks = 4'b0100;
    tick(acc);
    thanks = 4'b0000;
  endtask

  task automatic test_reset_mid();
    logic acc;
    valid_in = 1'b1; data_in = mk_hdr(2'd1, LW'(3));
    tick(acc);
    data_in = mk_body();
    tick(acc);
    data_in = mk_body();
    tick(acc);
    valid_in = 1'b0; thanks = 4'b0010;
    tick(acc);
    thanks = 4'b0000;
    total++; if (m_body !== 1'b1 || m_q.size() != 2) begin bad++; $display("[TB] FAIL mid_setup body=%b size=%0d want body=1 size=2", m_body, m_q.size()); end
    reset = 1'b1;
    tick(acc);
    reset = 1'b0;
    total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_valid got=%b want=0", valid_out); end
    total++; if (req !== 4'b0000) begin bad++; $display("[TB] FAIL mid_reset_req got=%b want=0000", req); end
    total++; if (yummy_out !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_yummy got=%b want=0", yummy_out); end
    valid_in = 1'b1; data_in = mk_hdr(2'd3, '0);
    tick(acc);
    valid_in = 1'b0;
    total++; if (req !== 4'b1000) begin bad++; $display("[TB] FAIL mid_new_req got=%b want=1000", req); end
    total++; if (tail_out !== 1'b1) begin bad++; $display("[TB] FAIL mid_new_tail got=%b want=1", tail_out); end
    thanks = 4'b1000;
    tick(acc);
    thanks = 4'b0000;
    total++; if (valid_out !== 1'b0) begin bad++; $display("[TB] FAIL mid_new_drain got=%b want=0", valid_out); end
  endtask

  initial begin
    m_body = 1'b0; m_cnt = '0; m_route = 2'd0; m_yummy = 1'b0;
    test_reset();
    test_single_flit();
    test_four_flit();
    test_full();
    test_back_to_back();
    test_max_len();
    test_reset_mid();
    test_wrong_thanks();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_xbar_input_port.md
Name: io_xbar_input_port

Overview:
- Receive side of the IO crossbar's valid/yummy credit link; one instance per crossbar input.
- Buffers incoming flits in a small FIFO and returns one yummy credit per flit popped.
- Decodes the header of each message to find its route and payload length, then raises a route request toward the chosen output port.
- Marks the tail flit and pops flits as the granted output port returns thanks.

Parameters:
- FIFO_DEPTH, 4, flit buffer depth; must be a power of 2 and at least 2; equals the upstream credit count.
- ROUTE_LSB, 0, LSB of the 2-bit route field in the header flit.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- data_in  input  `DATA_WIDTH  flit from the upstream link
- valid_in  input  1  flit valid; sent only when upstream holds a credit
- yummy_out  output  1  one-cycle credit return, one pulse per popped flit
- data_out  output  `DATA_WIDTH  flit at the FIFO head
- valid_out  output  1  FIFO not empty
- route_req_0_out..route_req_3_out  output  1 each  request to output port 0..3
- tail_out  output  1  head flit is the last flit of its message
- thanks_0_in..thanks_3_in  input  1 each  pop grant from output port 0..3

Interface decisions (Already decided):
- One clock, clk.
- Reset is synchronous and active-high, named reset.

Behaviour:
- Reset values: FIFO empty, valid_out=0, yummy_out=0, all route_req=0, tail_out=0, FSM=HEAD, length counter=0, route register=0. A reset asserted mid-message discards all buffered flits; credits are not returned.
- Push: valid_in=1 writes data_in at the write pointer. The flit is visible at data_out in the next cycle; there is no bypass path.
- Pop: the thanks bit of the latched route is high while valid_out=1.
  - Head advances next cycle.
  - yummy_out pulses in the cycle after the pop, so pop-to-credit latency is 1.
- Simultaneous push and pop: always legal, including when the FIFO is full; occupancy is unchanged.
- Overflow (push while full, no pop): the flit is dropped and the write pointer is held.
- Pointers wrap modulo FIFO_DEPTH. The occupancy counter is clog2(FIFO_DEPTH)+1 bits wide.
- FSM state HEAD (head flit is a header):
  - Route = data_out[ROUTE_LSB+1:ROUTE_LSB], presented combinationally on route_req_<route> when valid_out=1.
  - Length L = data_out[`DATA_WIDTH-`CHIP_ID_WIDTH-2*`XY_WIDTH-4 -: `PAYLOAD_LEN].
  - tail_out = valid_out & (L==0).
  - On pop: latch the route. If L==0, stay in HEAD. Otherwise load counter=L and go to BODY.
- FSM state BODY:
  - route_req_<latched route> = valid_out.
  - tail_out = valid_out & (counter==1).
  - Each pop decrements the counter; the pop with counter==1 returns to HEAD.
  - route_req stays asserted for the whole message, so the output arbiter holds the connection until the tail.
- Only one route_req bit is ever high at a time.
- Thanks on a non-selected port is ignored, as is thanks while valid_out=0. Neither pops the FIFO.
- In HEAD, the thanks bit used for the pop is the decoded route; in BODY it is the latched route.
- Maximum-length messages (L = 2^`PAYLOAD_LEN - 1) must count correctly with no counter overflow.

Optional Feature:
- Macro: IO_XBAR_INPUT_PROTOCOL_CHECK_EN.
- Defined: adds output err_out (1 bit, sticky until reset), set on any of:
  - overflow push;
  - thanks on a non-selected port while valid_out=1;
  - more than one thanks bit high in one cycle.
  - A simulation-only $display reports each event.
- Undefined: err_out is absent; error events are silently handled as described in Behaviour.

Decomposition:
- Shared package / network_define.v (existing): `DATA_WIDTH, `PAYLOAD_LEN, `CHIP_ID_WIDTH, `XY_WIDTH.
- Shared package additions: the IO_XBAR_ROUTE_0..3 encodings and the FSM state encodings (IO_XBAR_IN_HEAD, IO_XBAR_IN_BODY).
- Sub-module io_xbar_input_fifo:
  - Parameterised storage, pointers and occupancy.
  - Push/pop/full/empty interface.
  - Overflow drop.
- The top level holds the header decode, FSM, length counter, route latch and yummy register.

Test Plan:
- Single-flit message: header L=0, route=2 -> route_req_2_out=1 and tail_out=1 on the cycle after push; thanks_2_in pops it; yummy_out pulses 1 cycle later; FSM stays HEAD.
- 4-flit message: L=3, route=1, streamed back-to-back -> route_req_1_out held for all 4 flits; tail_out only on the 4th; exactly 4 yummy pulses.
- Wrong thanks: thanks_0_in asserted while the head is routed to port 3 -> no pop, no yummy; err_out=1 when the macro is defined.
- Full FIFO: 4 pushes with no thanks, then a 5th push -> 5th flit dropped, occupancy stays 4; a later push in the same cycle as a pop is accepted and occupancy stays 4.
- Back-to-back messages: route 0 with L=1, then route 3 with L=0 -> route_req switches 0 to 3 exactly after the tail pop; no cycle with two route_req bits high.
- Reset mid-message: reset during BODY with 2 flits buffered -> next cycle valid_out=0, FSM=HEAD; a new header is decoded correctly afterwards.
